// File: rtl/dmem_req_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_req_buffer
// Purpose  : Request-holding stage between the MEM pipeline stage and
//            mem_system. Latches one load/store, holds the mem_system
//            strobes/address/data stable until mem_Done, stalls the pipeline
//            meanwhile, and returns a one-cycle response with read data and
//            error status. Rejects misaligned/illegal requests, aborts on a
//            watchdog timeout and keeps saturating hit/miss counters.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_rd/req_wr/req_addr/req_wdata  - pipeline request
//            pipe_stall                                  - pipeline hold
//            rsp_valid/rsp_rdata/rsp_err                 - response pulse
//            mem_Addr/mem_DataIn/mem_Rd/mem_Wr           - to mem_system
//            mem_DataOut/mem_Done/mem_Stall/
//            mem_CacheHit/mem_err                        - from mem_system
//            hit_cnt/miss_cnt                            - saturating stats
// Revision : 1.0 - initial release
// ============================================================================
module dmem_req_buffer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        pipe_stall,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_Stall,
    input  logic        mem_CacheHit,
    input  logic        mem_err,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last BUSY watchdog value before the access is aborted.
    localparam logic [7:0] C_WDOG_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] wdata_q,    wdata_d;
    logic        rd_q,       rd_d;
    logic        wr_q,       wr_d;
    logic [7:0]  wdog_q,     wdog_d;
    logic        err_q,      err_d;
    logic [15:0] rdata_q,    rdata_d;
    logic [15:0] hit_cnt_q,  hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    logic        w_legal;
    logic        w_unused_stall;

    // Completion is signalled solely by mem_Done; mem_Stall is not needed.
    assign w_unused_stall = mem_Stall;

    // Exactly one of rd/wr and a halfword-aligned address.
    assign w_legal = (req_rd ^ req_wr) & ~req_addr[0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_legal) begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        rd_d    = req_rd;
                        wr_d    = req_wr;
                        wdog_d  = 8'd0;
                        err_d   = 1'b0;
                        state_d = ST_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                wdog_d = wdog_q + 8'd1;
                if (mem_err) begin
                    err_d = 1'b1;
                end
                // mem_Done takes priority over a coincident watchdog expiry.
                if (mem_Done) begin
                    rdata_d = rd_q ? mem_DataOut : 16'h0000;
                    if (mem_CacheHit) begin
                        hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q
                                                            : hit_cnt_q + 16'd1;
                    end else begin
                        miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q
                                                              : miss_cnt_q + 16'd1;
                    end
                    state_d = ST_RESP;
                end else if (wdog_q == C_WDOG_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 16'h0000;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // The request inputs still show the completed access here.
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdog_q     <= 8'd0;
            err_q      <= 1'b0;
            rdata_q    <= 16'h0000;
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Strobes are qualified by state so an asynchronous reset drops them at once.
    assign mem_Rd     = (state_q == ST_BUSY) & rd_q;
    assign mem_Wr     = (state_q == ST_BUSY) & wr_q;
    assign mem_Addr   = addr_q;
    assign mem_DataIn = wdata_q;

    assign pipe_stall = ((state_q == ST_IDLE) & req_valid) | (state_q == ST_BUSY);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_req_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_req_buffer
// Purpose  : Self-checking bench for dmem_req_buffer (TIMEOUT = 8). Directed
//            accesses push their hand-computed response into a queue; an
//            independent monitor pops and compares on every rsp_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_req_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        pipe_stall;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_Addr;
    logic [15:0] mem_DataIn;
    logic        mem_Rd;
    logic        mem_Wr;
    logic [15:0] mem_DataOut = 16'h0;
    logic        mem_Done = 1'b0;
    logic        mem_Stall = 1'b0;
    logic        mem_CacheHit = 1'b0;
    logic        mem_err = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    dmem_req_buffer #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .pipe_stall   (pipe_stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_Addr     (mem_Addr),
        .mem_DataIn   (mem_DataIn),
        .mem_Rd       (mem_Rd),
        .mem_Wr       (mem_Wr),
        .mem_DataOut  (mem_DataOut),
        .mem_Done     (mem_Done),
        .mem_Stall    (mem_Stall),
        .mem_CacheHit (mem_CacheHit),
        .mem_err      (mem_err),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [15:0] hit;
        logic [15:0] miss;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("hit_cnt", 32'(hit_cnt), 32'(e.hit));
                chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
            end
        end
    end

    // One request: lat = BUSY cycle index carrying mem_Done (1 = first BUSY
    // cycle), merr_k = BUSY cycle index carrying mem_err (0 = none).
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat, input logic hit,
                          input logic [15:0] dout, input int merr_k,
                          input logic [15:0] e_rdata, input logic e_err,
                          input logic [15:0] e_hit, input logic [15:0] e_miss,
                          input int e_delay);
        exp_t e;
        int   k;
        @(negedge clk);
        req_valid = 1'b1;
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.hit   = e_hit;
        e.miss  = e_miss;
        e.cyc   = cyc + e_delay;
        exp_q.push_back(e);
        #1;
        chk("stall_on_req", 32'(pipe_stall), 32'd1);
        k = 1;
        forever begin
            @(negedge clk);
            if (rsp_valid) break;
            if (k > 300) begin
                chk("rsp_wait", 32'(rsp_valid), 32'd1);
                break;
            end
            chk("busy_mem_rd", 32'(mem_Rd), 32'(rd));
            chk("busy_mem_wr", 32'(mem_Wr), 32'(wr));
            chk("busy_mem_addr", 32'(mem_Addr), 32'(addr));
            chk("busy_mem_datain", 32'(mem_DataIn), 32'(wdata));
            chk("busy_stall", 32'(pipe_stall), 32'd1);
            mem_Done     = (k == lat);
            mem_CacheHit = hit;
            mem_DataOut  = dout;
            mem_err      = (k == merr_k);
            k++;
        end
        mem_Done     = 1'b0;
        mem_err      = 1'b0;
        mem_CacheHit = 1'b0;
        chk("resp_no_strobe", 32'({mem_Rd, mem_Wr}), 32'd0);
        chk("resp_no_stall", 32'(pipe_stall), 32'd0);
        // Request still held through RESP; it must not be re-accepted.
        @(negedge clk);
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        #1;
        chk("idle_after_resp", 32'({pipe_stall, rsp_valid, mem_Rd, mem_Wr}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        chk("rst_mem", 32'({mem_Rd, mem_Wr, mem_Addr}), 32'd0);
        chk("rst_datain", 32'(mem_DataIn), 32'd0);
        chk("rst_cnt", {hit_cnt, miss_cnt}, 32'd0);
        req_valid = 1'b1;
        #1;
        chk("rst_stall_req", 32'(pipe_stall), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", 32'({pipe_stall, rsp_valid, mem_Rd, mem_Wr}), 32'd0);

        //     rd    wr    addr      wdata     lat   hit   dout      merr  rdata     err   hit       miss      dly
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 1,    1'b1, 16'hBEEF, 0,    16'hBEEF, 1'b0, 16'd1,    16'd0,    2);
        access(1'b0, 1'b1, 16'h0024, 16'h1234, 5,    1'b0, 16'hDEAD, 0,    16'h0000, 1'b0, 16'd1,    16'd1,    6);
        access(1'b1, 1'b0, 16'h0003, 16'h0000, 0,    1'b1, 16'h0000, 0,    16'h0000, 1'b1, 16'd1,    16'd1,    1);
        access(1'b1, 1'b1, 16'h0040, 16'h5555, 0,    1'b1, 16'h0000, 0,    16'h0000, 1'b1, 16'd1,    16'd1,    1);
        access(1'b0, 1'b0, 16'h0042, 16'h0000, 0,    1'b1, 16'h0000, 0,    16'h0000, 1'b1, 16'd1,    16'd1,    1);
        access(1'b1, 1'b0, 16'h0100, 16'h0000, 3,    1'b1, 16'h5A5A, 3,    16'h5A5A, 1'b1, 16'd2,    16'd1,    4);
        access(1'b0, 1'b1, 16'h0050, 16'hA5A5, 4,    1'b0, 16'h0000, 1,    16'h0000, 1'b1, 16'd2,    16'd2,    5);
        access(1'b1, 1'b0, 16'h0200, 16'h0000, 1000, 1'b0, 16'h7777, 0,    16'h0000, 1'b1, 16'd2,    16'd2,    9);
        access(1'b1, 1'b0, 16'h0300, 16'h0000, 8,    1'b0, 16'h0F0F, 0,    16'h0F0F, 1'b0, 16'd2,    16'd3,    9);

        // Reset while BUSY: strobe drops without a clock edge, late Done ignored.
        @(negedge clk);
        req_valid = 1'b1;
        req_rd    = 1'b1;
        req_addr  = 16'h0400;
        @(negedge clk);
        chk("busy_before_rst", 32'(mem_Rd), 32'd1);
        req_valid = 1'b0;
        req_rd    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rd_drop_async", 32'({mem_Rd, pipe_stall}), 32'd0);
        @(negedge clk);
        rst          = 1'b1;
        mem_Done     = 1'b1;
        mem_CacheHit = 1'b1;
        mem_DataOut  = 16'h1111;
        @(negedge clk);
        mem_Done     = 1'b0;
        mem_CacheHit = 1'b0;
        chk("late_done_rsp", 32'(rsp_valid), 32'd0);
        chk("late_done_cnt", {hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk);
        chk("late_done_rsp2", 32'(rsp_valid), 32'd0);

        // Hit counter saturation from a preloaded value.
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFE;
        #1;
        release dut.hit_cnt_q;
        chk("hit_preload", 32'(hit_cnt), 32'h0000FFFE);
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1'b1, 16'h0001, 0, 16'h0001, 1'b0, 16'hFFFF, 16'd0, 2);
        access(1'b1, 1'b0, 16'h0012, 16'h0000, 1, 1'b1, 16'h0002, 0, 16'h0002, 1'b0, 16'hFFFF, 16'd0, 2);
        access(1'b0, 1'b1, 16'h0014, 16'h9999, 2, 1'b0, 16'h0003, 0, 16'h0000, 1'b0, 16'hFFFF, 16'd1, 3);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
